// File: rtl/cnn_result_tx.sv
// UART 8N1 transmitter for CNN result bytes, fed through a small FIFO.
// Define CNN_TX_PARITY_EN to insert an even-parity bit between data and stop.
module cnn_result_tx #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       bsy,
  output logic       full,
  output logic       ovf,
  output logic [2:0] o_dbg_state
);

  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_PAR   = 3'd4;

  // Handshake: trmt is a single-cycle strobe with no ready; a strobe that
  // finds the FIFO full and no pop in the same cycle is dropped and sets ovf.

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;

  logic [2:0]  r_state;
  logic [11:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_done;
  logic        r_bsy;
`ifdef CNN_TX_PARITY_EN
  logic        r_par;
`endif

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [FIFO_AW:0] w_count_nxt;
  logic [7:0]       w_head;
  logic             w_baud_exp;
  logic [2:0]       w_state_nxt;

  assign w_full      = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_push      = trmt && (!w_full || w_pop);
  assign w_drop      = trmt && w_full && !w_pop;
  assign w_count_nxt = r_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_exp  = (r_baud == 12'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_ovf    <= 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_START;
      S_START: if (w_baud_exp) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_baud_exp && (r_bit == 3'd7)) begin
`ifdef CNN_TX_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef CNN_TX_PARITY_EN
      S_PAR:   if (w_baud_exp) w_state_nxt = S_STOP;
`endif
      S_STOP:  if (w_baud_exp) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // TX is always updated one edge ahead, so the line reflects each bit
  // exactly on the edge the baud counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_bsy   <= 1'b0;
`ifdef CNN_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      r_bsy   <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
      if (r_state == S_IDLE) begin
        r_baud <= '0;
        if (w_pop) begin
          r_shift <= w_head;
          r_bit   <= '0;
          r_tx    <= 1'b0;
`ifdef CNN_TX_PARITY_EN
          r_par   <= ^w_head;
`endif
        end
      end else begin
        r_baud <= w_baud_exp ? 12'd0 : r_baud + 12'd1;
        if (w_baud_exp) begin
          case (r_state)
            S_START: r_tx <= r_shift[0];
            S_DATA: begin
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
`ifdef CNN_TX_PARITY_EN
                r_tx <= r_par;
`else
                r_tx <= 1'b1;
`endif
              end else begin
                r_tx <= r_shift[1];
              end
            end
            S_STOP: begin
              r_tx   <= 1'b1;
              r_done <= 1'b1;
            end
            default: r_tx <= 1'b1;
          endcase
        end
      end
    end
  end

  assign TX          = r_tx;
  assign tx_done     = r_done;
  assign bsy         = r_bsy;
  assign full        = w_full;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cnn_result_tx.sv
// Directed bench for cnn_result_tx: line monitor, expected-byte queue, summary.
module tb_cnn_result_tx;

  localparam int B = 4;
`ifdef CNN_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_done;
  logic       bsy;
  logic       full;
  logic       ovf;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];

  cnn_result_tx #(.BAUD_DIV(B), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
    .TX(tx), .tx_done(tx_done), .bsy(bsy), .full(full), .ovf(ovf),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef CNN_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // line monitor: decode frames at mid-bit, record start cycle
  always begin : monitor
    logic [7:0] b;
    @(negedge clk);
    if (mon_en && rst_n && tx === 1'b0) begin
      start_q.push_back(cyc);
      repeat (B + B/2 - 1) @(negedge clk);
      b[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (B) @(negedge clk);
        b[i] = tx;
      end
`ifdef CNN_TX_PARITY_EN
      repeat (B) @(negedge clk);
      chk("mon_parity", tx, ^b);
`endif
      repeat (B) @(negedge clk);
      chk("mon_stop", tx, 1'b1);
      rx_q.push_back(b);
    end
  end

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic pulse(input logic [7:0] b);
    trmt = 1'b1;
    tx_data = b;
    @(negedge clk);
    trmt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", (done_cnt >= target), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic flush_sb(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) chk(tag, rx_q.pop_front(), e);
      else chk({tag, "_missing"}, 0, e);
    end
    chk({tag, "_extra"}, rx_q.size(), 0);
    rx_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int sq;
    logic [7:0] b35;
    rst_n = 1'b0;
    trmt = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_bsy", bsy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single byte, cycle-exact line check
    b35 = 8'h35;
    exp_q.push_back(b35);
    pulse(b35);
    chk("s_bsy_k", bsy, 1);
    chk("s_tx_k", tx, 1);
    chk("s_state_k", dbg_state, 0);
    for (int c = 1; c <= B * NBITS; c++) begin
      @(negedge clk);
      chk("s_tx", tx, frame_bit(b35, (c - 1) / B));
      chk("s_done_lo", tx_done, 0);
    end
    @(negedge clk);
    chk("s_done", tx_done, 1);
    chk("s_bsy_end", bsy, 0);
    chk("s_state_end", dbg_state, 0);
    chk("s_tx_end", tx, 1);
    @(negedge clk);
    chk("s_done_one", tx_done, 0);
    repeat (3) @(negedge clk);
    flush_sb("single_rx");

    // back-to-back
    base = done_cnt;
    sq = start_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    pulse(8'h00);
    pulse(8'hFF);
    wait_done(base + 2);
    chk("b2b_starts", start_q.size(), sq + 2);
    if (start_q.size() >= sq + 2)
      chk("b2b_period", start_q[sq+1] - start_q[sq], B * NBITS + 1);
    chk("b2b_bsy", bsy, 0);
    chk("b2b_full", full, 0);
    chk("b2b_dones", done_cnt, base + 2);
    flush_sb("b2b_rx");

    // overflow: sixth strobe dropped
    base = done_cnt;
    for (int i = 1; i <= 6; i++) begin
      trmt = 1'b1;
      tx_data = 8'(i);
      @(negedge clk);
    end
    trmt = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    chk("ovf_set", ovf, 1);
    chk("ovf_full", full, 1);
    wait_done(base + 5);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_bsy", bsy, 0);
    chk("ovf_dones", done_cnt, base + 5);
    flush_sb("ovf_rx");

    // full with simultaneous pop
    do_reset();
    chk("fp_ovf_clr", ovf, 0);
    base = done_cnt;
    pulse(8'h11);
    pulse(8'h21);
    pulse(8'h22);
    pulse(8'h23);
    pulse(8'h24);
    chk("fp_full", full, 1);
    begin
      int t;
      t = 0;
      while (tx_done !== 1'b1 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk("fp_wait_done", tx_done, 1);
    end
    pulse(8'hA5);
    chk("fp_ovf", ovf, 0);
    chk("fp_full_kept", full, 1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h24);
    exp_q.push_back(8'hA5);
    wait_done(base + 6);
    chk("fp_ovf_end", ovf, 0);
    flush_sb("fp_rx");

    // reset mid-frame during data bit 3 of 0xC3
    mon_en = 1'b0;
    pulse(8'hC3);
    repeat (17) @(negedge clk);
    chk("mr_bit3", tx, 0);
    chk("mr_state", dbg_state, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_tx_async", tx, 1);
    chk("mr_bsy", bsy, 0);
    chk("mr_done", tx_done, 0);
    chk("mr_state_rst", dbg_state, 0);
    base = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("mr_no_done", done_cnt, base);
    chk("mr_tx_idle", tx, 1);
    chk("mr_bsy_idle", bsy, 0);
    chk("mr_full", full, 0);
    rx_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h5A);
    pulse(8'h5A);
    wait_done(base + 1);
    flush_sb("mr_rx");

`ifdef CNN_TX_PARITY_EN
    base = done_cnt;
    exp_q.push_back(8'h07);
    pulse(8'h07);
    repeat (B * 9) @(negedge clk);
    @(negedge clk);
    chk("par_bit", tx, 1);
    wait_done(base + 1);
    flush_sb("par_rx");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
